// File: rtl/mem_sched.sv
// Picks at most one of instruction fetch / data access per cycle, issues it to memory one cycle later, tracks read IDs.
// Latency: grant combinational, o_mem_* registered next edge; i_mem_full or a full ID table withholds grants (stores bypass the table).
module mem_sched #(
   parameter int PA_WIDTH        = 32,
   parameter int LINE_WIDTH      = 128,
   parameter int ID_WIDTH        = 3,
   parameter int MAX_OUTSTANDING = 8,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_instr_enable,
   input  logic [PA_WIDTH-1:0]   i_instr_addr,
   output logic                  o_instr_grant,
   input  logic                  i_data_enable,
   input  logic [PA_WIDTH-1:0]   i_data_addr,
   input  logic [LINE_WIDTH-1:0] i_data,
   input  logic                  i_data_write,
   output logic                  o_data_grant,
   input  logic                  i_mem_full,
   output logic                  o_mem_enable,
   output logic [PA_WIDTH-1:0]   o_mem_addr,
   output logic [LINE_WIDTH-1:0] o_mem_data,
   output logic                  o_mem_write,
   output logic [ID_WIDTH-1:0]   o_mem_id,
   input  logic                  i_mem_resp_enable,
   input  logic [ID_WIDTH-1:0]   i_mem_resp_id,
   output logic                  o_resp_instr,
   output logic                  o_resp_data,
   output logic [ID_WIDTH:0]     o_outstanding,
   output logic                  o_resp_error
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [MAX_OUTSTANDING-1:0] busy_q, owner_q;
   logic [MAX_OUTSTANDING-1:0] resp_clr, alloc_set;
   logic [CW-1:0]              starve_q;
   logic                       free_any;
   logic [ID_WIDTH-1:0]        free_id;
   logic                       instr_elig, data_elig, starve_max;
   logic                       instr_win, data_win, read_grant;
   logic                       resp_hit, resp_owner;
   logic [ID_WIDTH:0]          busy_cnt;

   // Lowest free ID comes from the registered mask, so an ID freed this cycle is not reused until next cycle.
   always_comb begin
      free_any = 1'b0;
      free_id  = '0;
      for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_any = 1'b1;
            free_id  = ID_WIDTH'(i);
         end
      end
   end

   assign instr_elig = i_instr_enable && !i_mem_full && free_any;
   assign data_elig  = i_data_enable && !i_mem_full && (i_data_write || free_any);
   assign starve_max = (starve_q == CW'(STARVE_LIMIT));
   assign instr_win  = instr_elig && (!data_elig || starve_max);
   assign data_win   = data_elig && !instr_win;
   assign read_grant = instr_win || (data_win && !i_data_write);

   assign o_instr_grant = instr_win;
   assign o_data_grant  = data_win;

   always_comb begin
      resp_hit   = 1'b0;
      resp_owner = 1'b0;
      resp_clr   = '0;
      alloc_set  = '0;
      busy_cnt   = '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (i_mem_resp_enable && (i_mem_resp_id == ID_WIDTH'(i)) && busy_q[i]) begin
            resp_hit    = 1'b1;
            resp_owner  = owner_q[i];
            resp_clr[i] = 1'b1;
         end
         alloc_set[i] = read_grant && (free_id == ID_WIDTH'(i));
         busy_cnt     = busy_cnt + (ID_WIDTH + 1)'(busy_q[i]);
      end
   end

   assign o_resp_instr  = resp_hit && !resp_owner;
   assign o_resp_data   = resp_hit && resp_owner;
   assign o_outstanding = busy_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q       <= '0;
         owner_q      <= '0;
         starve_q     <= '0;
         o_resp_error <= 1'b0;
      end else begin
         busy_q <= (busy_q & ~resp_clr) | alloc_set;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (alloc_set[i]) owner_q[i] <= data_win;
         end
         if (i_mem_resp_enable && !resp_hit) o_resp_error <= 1'b1;
         // Only a real arbitration loss counts; a full table or i_mem_full leaves the count alone.
         if (!i_instr_enable || instr_win) starve_q <= '0;
         else if (instr_elig && data_win && !starve_max) starve_q <= starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_mem_enable <= 1'b0;
         o_mem_addr   <= '0;
         o_mem_data   <= '0;
         o_mem_write  <= 1'b0;
         o_mem_id     <= '0;
      end else begin
         o_mem_enable <= instr_win || data_win;
         if (instr_win) begin
            o_mem_addr  <= i_instr_addr;
            o_mem_write <= 1'b0;
            o_mem_id    <= free_id;
         end else if (data_win) begin
            o_mem_addr  <= i_data_addr;
            o_mem_data  <= i_data;
            o_mem_write <= i_data_write;
            o_mem_id    <= i_data_write ? '0 : free_id;
         end
      end
   end

endmodule

// File: tb/tb_mem_sched.sv
// Directed bench for mem_sched: expected issues and responses are queued by the stimulus and checked by a monitor.
module tb_mem_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_instr_enable;
   logic [31:0]  i_instr_addr;
   logic         o_instr_grant;
   logic         i_data_enable;
   logic [31:0]  i_data_addr;
   logic [127:0] i_data;
   logic         i_data_write;
   logic         o_data_grant;
   logic         i_mem_full;
   logic         o_mem_enable;
   logic [31:0]  o_mem_addr;
   logic [127:0] o_mem_data;
   logic         o_mem_write;
   logic [2:0]   o_mem_id;
   logic         i_mem_resp_enable;
   logic [2:0]   i_mem_resp_id;
   logic         o_resp_instr;
   logic         o_resp_data;
   logic [3:0]   o_outstanding;
   logic         o_resp_error;

   mem_sched dut (
      .clk(clk), .rst(rst),
      .i_instr_enable(i_instr_enable), .i_instr_addr(i_instr_addr), .o_instr_grant(o_instr_grant),
      .i_data_enable(i_data_enable), .i_data_addr(i_data_addr), .i_data(i_data),
      .i_data_write(i_data_write), .o_data_grant(o_data_grant),
      .i_mem_full(i_mem_full), .o_mem_enable(o_mem_enable), .o_mem_addr(o_mem_addr),
      .o_mem_data(o_mem_data), .o_mem_write(o_mem_write), .o_mem_id(o_mem_id),
      .i_mem_resp_enable(i_mem_resp_enable), .i_mem_resp_id(i_mem_resp_id),
      .o_resp_instr(o_resp_instr), .o_resp_data(o_resp_data),
      .o_outstanding(o_outstanding), .o_resp_error(o_resp_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  addr;
      logic [127:0] data;
      logic         wr;
      logic [2:0]   id;
   } iss_t;

   iss_t iss_q[$];
   bit   resp_q[$];   // 1 = data owner, 0 = instruction owner
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic gchk(input string nm, input logic ig, input logic dg);
      @(negedge clk);
      chk({nm, " instr_grant"}, o_instr_grant, ig);
      chk({nm, " data_grant"}, o_data_grant, dg);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst && o_mem_enable) begin
         if (iss_q.size() == 0) chk("unexpected mem issue", 1'b1, 1'b0);
         else begin
            iss_t e;
            e = iss_q.pop_front();
            chk("mem_addr", o_mem_addr, e.addr);
            chk("mem_write", o_mem_write, e.wr);
            chk("mem_id", o_mem_id, e.id);
            if (e.wr) chk("mem_data", o_mem_data, e.data);
         end
      end
      if (o_resp_instr || o_resp_data) begin
         if (resp_q.size() == 0) chk("unexpected resp pulse", 1'b1, 1'b0);
         else begin
            bit d;
            d = resp_q.pop_front();
            chk("resp_instr", o_resp_instr, !d);
            chk("resp_data", o_resp_data, d);
         end
      end
   end

   initial begin
      bit prev_owner;
      rst = 1'b0;
      i_instr_enable = 0; i_instr_addr = '0;
      i_data_enable = 0; i_data_addr = '0; i_data = '0; i_data_write = 0;
      i_mem_full = 0; i_mem_resp_enable = 0; i_mem_resp_id = '0;

      @(negedge clk);
      chk("rst mem_enable", o_mem_enable, 0);
      chk("rst mem_addr", o_mem_addr, 0);
      chk("rst mem_data", o_mem_data, 0);
      chk("rst mem_write", o_mem_write, 0);
      chk("rst mem_id", o_mem_id, 0);
      chk("rst outstanding", o_outstanding, 0);
      chk("rst resp_error", o_resp_error, 0);
      adv();
      rst = 1'b1;
      adv();

      // Single instruction read and its response
      i_instr_enable = 1; i_instr_addr = 32'h100;
      iss_q.push_back('{32'h100, 128'h0, 1'b0, 3'd0});
      gchk("t1", 1, 0); adv();
      i_instr_enable = 0;
      @(negedge clk); chk("t1 outstanding", o_outstanding, 1); adv();
      i_mem_resp_enable = 1; i_mem_resp_id = 0; resp_q.push_back(1'b0);
      gchk("t1 resp", 0, 0); adv();
      i_mem_resp_enable = 0;
      @(negedge clk); chk("t1 outstanding after resp", o_outstanding, 0); adv();

      // Starvation: data wins 4 times, then instruction; responses retire the previous issue
      i_instr_enable = 1; i_instr_addr = 32'h200;
      i_data_enable = 1; i_data_addr = 32'h300; i_data_write = 0;
      prev_owner = 0;
      for (int k = 0; k < 10; k++) begin
         bit iw;
         iw = (k % 5 == 4);
         if (k > 0) begin
            i_mem_resp_enable = 1; i_mem_resp_id = 3'((k - 1) % 2);
            resp_q.push_back(prev_owner);
         end
         iss_q.push_back('{iw ? 32'h200 : 32'h300, 128'h0, 1'b0, 3'(k % 2)});
         gchk($sformatf("starve k=%0d", k), iw, !iw); adv();
         prev_owner = !iw;
      end
      i_instr_enable = 0; i_data_enable = 0;
      i_mem_resp_enable = 1; i_mem_resp_id = 3'd1; resp_q.push_back(prev_owner);
      gchk("starve tail", 0, 0); adv();
      i_mem_resp_enable = 0;
      @(negedge clk); chk("starve outstanding", o_outstanding, 0); adv();

      // Fill all 8 IDs with data loads
      i_data_enable = 1; i_data_write = 0;
      for (int k = 0; k < 8; k++) begin
         i_data_addr = 32'h1000 + 32'(k) * 32'h40;
         iss_q.push_back('{i_data_addr, 128'h0, 1'b0, 3'(k)});
         gchk($sformatf("fill k=%0d", k), 0, 1); adv();
      end
      i_data_addr = 32'h1200;
      gchk("full load blocked", 0, 0);
      chk("full outstanding", o_outstanding, 8);
      adv();

      // Stores still post with the table full; instruction is blocked and must not accrue starvation
      i_instr_enable = 1; i_instr_addr = 32'h700;
      i_data_write = 1;
      for (int k = 0; k < 4; k++) begin
         i_data_addr = 32'h5000 + 32'(k);
         i_data = {32'hDEADBEEF, 96'(k + 1)};
         iss_q.push_back('{i_data_addr, i_data, 1'b1, 3'd0});
         gchk($sformatf("store k=%0d", k), 0, 1); adv();
      end

      // Free ID 3 while a load waits: reuse only on the following cycle
      i_data_write = 0; i_data_addr = 32'h6000;
      i_mem_resp_enable = 1; i_mem_resp_id = 3'd3; resp_q.push_back(1'b1);
      gchk("free+load same cycle", 0, 0); adv();
      i_mem_resp_enable = 0;
      iss_q.push_back('{32'h6000, 128'h0, 1'b0, 3'd3});
      gchk("load reuses id3", 0, 1); adv();
      i_data_enable = 0;
      gchk("instr blocked full", 0, 0); adv();
      i_instr_enable = 0;

      for (int k = 0; k < 8; k++) begin
         i_mem_resp_enable = 1; i_mem_resp_id = 3'(k); resp_q.push_back(1'b1);
         gchk($sformatf("drain id=%0d", k), 0, 0); adv();
      end
      i_mem_resp_enable = 0;
      @(negedge clk); chk("drain outstanding", o_outstanding, 0); adv();

      // Memory backpressure for 3 cycles
      i_mem_full = 1;
      i_instr_enable = 1; i_instr_addr = 32'h800;
      i_data_enable = 1; i_data_addr = 32'h8000; i_data_write = 0;
      for (int k = 0; k < 3; k++) begin
         gchk($sformatf("memfull k=%0d", k), 0, 0);
         chk("memfull mem_enable", o_mem_enable, 0);
         adv();
      end
      i_mem_full = 0;
      iss_q.push_back('{32'h8000, 128'h0, 1'b0, 3'd0});
      gchk("memfull release", 0, 1); adv();
      i_instr_enable = 0; i_data_enable = 0;
      i_mem_resp_enable = 1; i_mem_resp_id = 3'd0; resp_q.push_back(1'b1);
      gchk("memfull resp", 0, 0); adv();
      i_mem_resp_enable = 0;

      // Response to an unallocated ID
      @(negedge clk); chk("error before", o_resp_error, 0); adv();
      i_mem_resp_enable = 1; i_mem_resp_id = 3'd5;
      @(negedge clk);
      chk("bad id resp_instr", o_resp_instr, 0);
      chk("bad id resp_data", o_resp_data, 0);
      adv();
      i_mem_resp_enable = 0;
      @(negedge clk); chk("error set", o_resp_error, 1); adv();
      adv(); adv();
      @(negedge clk); chk("error sticky", o_resp_error, 1); adv();

      // Asynchronous reset with a read just issued
      i_instr_enable = 1; i_instr_addr = 32'h900;
      gchk("pre-reset", 1, 0);
      @(posedge clk); #1;
      i_instr_enable = 0;
      chk("pre-reset mem_enable", o_mem_enable, 1);
      chk("pre-reset outstanding", o_outstanding, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst mem_enable", o_mem_enable, 0);
      chk("arst mem_addr", o_mem_addr, 0);
      chk("arst mem_data", o_mem_data, 0);
      chk("arst mem_id", o_mem_id, 0);
      chk("arst outstanding", o_outstanding, 0);
      chk("arst resp_error", o_resp_error, 0);
      adv();
      rst = 1'b1;
      i_mem_resp_enable = 1; i_mem_resp_id = 3'd0;
      @(negedge clk);
      chk("stale resp_instr", o_resp_instr, 0);
      chk("stale resp_data", o_resp_data, 0);
      adv();
      i_mem_resp_enable = 0;
      @(negedge clk); chk("stale resp error", o_resp_error, 1); adv();

      chk("issue queue drained", iss_q.size(), 0);
      chk("resp queue drained", resp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
